intersection_scheduler: RTL and testbench

- Phase sequencer for the traffic intersection.
- Arbitrates the shared "right of way" resource among three requesters: main road, side road (vehicle sensor) and pedestrian walk button.
- Drives main/side light codes and the walk light, with minimum-green, sensor extension, yellow and all-red clearance timing counted in ticks of an external timebase enable.
- Sits between the input debouncers/tick divider and the lamp drivers.

---
 rtl/traffic_pkg.sv | 29 ++
 rtl/intersection_scheduler_phase_timer.sv | 32 +++
 rtl/intersection_scheduler.sv | 146 ++++++++++++++
 tb/tb_intersection_scheduler.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared light codes, phase encodings and default timing for the intersection blocks.
// FLASH_MODE_EN adds the FLASH phase encoding.
package traffic_pkg;

   localparam logic [1:0] LIGHT_OFF   = 2'd0;
   localparam logic [1:0] LIGHT_GREEN = 2'd1;
   localparam logic [1:0] LIGHT_YEL   = 2'd2;
   localparam logic [1:0] LIGHT_RED   = 2'd3;

   typedef enum logic [2:0] {
      ALL_RED    = 3'd0,
      MAIN_GREEN = 3'd1,
      MAIN_YEL   = 3'd2,
      SIDE_GREEN = 3'd3,
      SIDE_YEL   = 3'd4,
      WALK       = 3'd5
`ifdef FLASH_MODE_EN
      ,FLASH     = 3'd6
`endif
   } phase_e;

   localparam int unsigned DEF_CW       = 4;
   localparam int unsigned DEF_T_BASE   = 6;
   localparam int unsigned DEF_T_EXT    = 3;
   localparam int unsigned DEF_T_YEL    = 2;
   localparam int unsigned DEF_T_WALK   = 3;
   localparam int unsigned DEF_T_ALLRED = 1;

endpackage

// File: rtl/intersection_scheduler_phase_timer.sv
// Tick counter for one phase: clears on phase change, optionally saturates at the
// terminal count, and flags the tick that ends a phase of length dur.
module phase_timer
   import traffic_pkg::*;
#(
   parameter int unsigned CW = DEF_CW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          tick,
   input  logic          clear,
   input  logic          sat,
   input  logic [CW-1:0] dur,
   output logic          done
);

   logic [CW-1:0] count;
   logic          at_end;

   assign at_end = (count == dur - CW'(1));
   assign done   = tick & at_end;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (tick && !(sat && at_end))
         count <= count + CW'(1);
   end

endmodule

// File: rtl/intersection_scheduler.sv
// Intersection phase sequencer: arbitrates main road, side road and pedestrian walk.
// Define FLASH_MODE_EN to add the flash input and the FLASH phase.
module intersection_scheduler
   import traffic_pkg::*;
#(
   parameter int unsigned CW       = DEF_CW,
   parameter int unsigned T_BASE   = DEF_T_BASE,
   parameter int unsigned T_EXT    = DEF_T_EXT,
   parameter int unsigned T_YEL    = DEF_T_YEL,
   parameter int unsigned T_WALK   = DEF_T_WALK,
   parameter int unsigned T_ALLRED = DEF_T_ALLRED
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       side_sensor,
   input  logic       walk_btn,
`ifdef FLASH_MODE_EN
   input  logic       flash,
`endif
   output logic [1:0] main_light,
   output logic [1:0] side_light,
   output logic       walk_light,
   output logic [2:0] phase
);

   if (T_BASE + T_EXT - 1 >= (1 << CW) || T_YEL - 1 >= (1 << CW) ||
       T_WALK - 1 >= (1 << CW) || T_ALLRED - 1 >= (1 << CW) ||
       T_BASE == 0 || T_EXT == 0 || T_YEL == 0 || T_WALK == 0 || T_ALLRED == 0) begin : g_bad_timing
      $error("intersection_scheduler: durations must be >= 1 and fit in CW bits");
   end

   phase_e        state, state_next;
   logic          side_req, walk_req, ext_used, walk_from_main;
   logic          side_set, side_clr, walk_set, walk_clr;
   logic          done, extend, clear;
   logic [CW-1:0] dur;
   logic [1:0]    main_d, side_d;
   logic          walk_d;
`ifdef FLASH_MODE_EN
   logic          flash_on, flash_on_next;
   assign flash_on_next = (state == FLASH) ? (flash_on ^ tick) : 1'b1;
`endif

   // done with no extension used means the minimum side green has just elapsed
   assign extend = (state == SIDE_GREEN) && done && side_sensor && !ext_used;
   assign clear  = (state_next != state);
   assign phase  = state;

   phase_timer #(.CW(CW)) u_timer (
      .clk   (clk),
      .reset (reset),
      .tick  (tick),
      .clear (clear),
      .sat   (state == MAIN_GREEN),
      .dur   (dur),
      .done  (done)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= ALL_RED;
         side_req       <= 1'b0;
         walk_req       <= 1'b0;
         ext_used       <= 1'b0;
         walk_from_main <= 1'b0;
         main_light     <= LIGHT_RED;
         side_light     <= LIGHT_RED;
         walk_light     <= 1'b0;
`ifdef FLASH_MODE_EN
         flash_on       <= 1'b0;
`endif
      end else begin
         state      <= state_next;
         main_light <= main_d;
         side_light <= side_d;
         walk_light <= walk_d;
         side_req   <= !side_clr && (side_req || side_set);
         walk_req   <= !walk_clr && (walk_req || walk_set);
         ext_used   <= (state_next == SIDE_GREEN) && (ext_used || extend);
         if (state_next == WALK && state != WALK)
            walk_from_main <= (state == MAIN_YEL);
`ifdef FLASH_MODE_EN
         flash_on   <= flash_on_next;
`endif
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ALL_RED:    if (done) state_next = MAIN_GREEN;
         MAIN_GREEN: if (done && (side_req || walk_req)) state_next = MAIN_YEL;
         MAIN_YEL:   if (done) state_next = walk_req ? WALK : (side_req ? SIDE_GREEN : MAIN_GREEN);
         WALK:       if (done) state_next = (side_req && walk_from_main) ? SIDE_GREEN : MAIN_GREEN;
         SIDE_GREEN: if (done && !extend) state_next = SIDE_YEL;
         SIDE_YEL:   if (done) state_next = walk_req ? WALK : MAIN_GREEN;
         default:    state_next = ALL_RED;
      endcase
`ifdef FLASH_MODE_EN
      if (flash) state_next = FLASH;
`endif

      dur = CW'(T_ALLRED);
      case (state)
         MAIN_GREEN:         dur = CW'(T_BASE);
         MAIN_YEL, SIDE_YEL: dur = CW'(T_YEL);
         WALK:               dur = CW'(T_WALK);
         SIDE_GREEN:         dur = ext_used ? CW'(T_BASE + T_EXT) : CW'(T_BASE);
         default:            dur = CW'(T_ALLRED);
      endcase

      // entry clear overrides a same-cycle set: the request is being served
      side_set = side_sensor && (state != SIDE_GREEN) && (state != SIDE_YEL);
      side_clr = (state_next == SIDE_GREEN) && (state != SIDE_GREEN);
      walk_set = walk_btn && (state != WALK);
      walk_clr = (state_next == WALK) && (state != WALK);
`ifdef FLASH_MODE_EN
      if (state_next == FLASH) begin
         side_clr = 1'b1;
         walk_clr = 1'b1;
      end
`endif
   end

   always_comb begin
      main_d = LIGHT_RED;
      side_d = LIGHT_RED;
      walk_d = 1'b0;
      case (state_next)
         MAIN_GREEN: main_d = LIGHT_GREEN;
         MAIN_YEL:   main_d = LIGHT_YEL;
         SIDE_GREEN: side_d = LIGHT_GREEN;
         SIDE_YEL:   side_d = LIGHT_YEL;
         WALK:       walk_d = 1'b1;
`ifdef FLASH_MODE_EN
         FLASH: begin
            main_d = flash_on_next ? LIGHT_YEL : LIGHT_OFF;
            side_d = flash_on_next ? LIGHT_RED : LIGHT_OFF;
         end
`endif
         default: ;
      endcase
   end

endmodule

// File: tb/tb_intersection_scheduler.sv
// Scoreboard bench for intersection_scheduler: a behavioural phase model pushes the
// expected registered outputs each cycle, popped and compared after the clock edge.
module tb_intersection_scheduler;
   import traffic_pkg::*;

   localparam int T_BASE   = 6;
   localparam int T_EXT    = 3;
   localparam int T_YEL    = 2;
   localparam int T_WALK   = 3;
   localparam int T_ALLRED = 1;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       tick = 1'b0;
   logic       side_sensor = 1'b0;
   logic       walk_btn = 1'b0;
   logic       flash = 1'b0;
   logic [1:0] main_light, side_light;
   logic       walk_light;
   logic [2:0] phase;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   logic [7:0] sb[$];

   phase_e ms;
   int     el;
   bit     sreq, wreq, ext, from_main;

   intersection_scheduler #(
      .CW(4), .T_BASE(T_BASE), .T_EXT(T_EXT), .T_YEL(T_YEL),
      .T_WALK(T_WALK), .T_ALLRED(T_ALLRED)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .tick        (tick),
      .side_sensor (side_sensor),
      .walk_btn    (walk_btn),
`ifdef FLASH_MODE_EN
      .flash       (flash),
`endif
      .main_light  (main_light),
      .side_light  (side_light),
      .walk_light  (walk_light),
      .phase       (phase)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s cycle=%0d got=%h want=%h", tag, cyc, got, want);
      end
   endtask

   function automatic logic [7:0] expect_of(input phase_e p);
      logic [1:0] m, s;
      logic       w;
      m = 2'd3; s = 2'd3; w = 1'b0;
      case (p)
         MAIN_GREEN: m = 2'd1;
         MAIN_YEL:   m = 2'd2;
         SIDE_GREEN: s = 2'd1;
         SIDE_YEL:   s = 2'd2;
         WALK:       w = 1'b1;
         default: ;
      endcase
      return {p, m, s, w};
   endfunction

   task automatic model_reset();
      ms = ALL_RED; el = 0; sreq = 0; wreq = 0; ext = 0; from_main = 0;
   endtask

   task automatic model_step(input bit tk, input bit sen, input bit btn);
      phase_e nx;
      bit     ext_now;
      nx = ms;
      ext_now = 0;
      if (tk) begin
         case (ms)
            ALL_RED:    if (el + 1 == T_ALLRED) nx = MAIN_GREEN;
            MAIN_GREEN: if (el + 1 >= T_BASE && (sreq || wreq)) nx = MAIN_YEL;
            MAIN_YEL:   if (el + 1 == T_YEL) nx = wreq ? WALK : (sreq ? SIDE_GREEN : MAIN_GREEN);
            WALK:       if (el + 1 == T_WALK) nx = (sreq && from_main) ? SIDE_GREEN : MAIN_GREEN;
            SIDE_GREEN: begin
               if (!ext && el + 1 == T_BASE && sen) ext_now = 1;
               else if (el + 1 == (ext ? T_BASE + T_EXT : T_BASE)) nx = SIDE_YEL;
            end
            SIDE_YEL:   if (el + 1 == T_YEL) nx = wreq ? WALK : MAIN_GREEN;
            default:    nx = ALL_RED;
         endcase
      end
      if (sen && ms != SIDE_GREEN && ms != SIDE_YEL) sreq = 1;
      if (btn && ms != WALK) wreq = 1;
      if (nx == SIDE_GREEN && ms != SIDE_GREEN) sreq = 0;
      if (nx == WALK && ms != WALK) begin
         wreq = 0;
         from_main = (ms == MAIN_YEL);
      end
      ext = (nx == SIDE_GREEN) && (ext || ext_now);
      if (nx != ms) el = 0;
      else if (tk) el++;
      ms = nx;
   endtask

   task automatic step(input bit tk, input bit sen, input bit btn);
      logic [7:0] want;
      tick = tk; side_sensor = sen; walk_btn = btn;
      model_step(tk, sen, btn);
      sb.push_back(expect_of(ms));
      @(posedge clk);
      #1;
      cyc++;
      if (sb.size() == 0) begin
         check("scoreboard_empty", 8'h00, 8'hff);
      end else begin
         want = sb.pop_front();
         check("outputs", {phase, main_light, side_light, walk_light}, want);
      end
   endtask

   task automatic run_until(input phase_e target, input int budget);
      int n;
      n = 0;
      while (ms != target && n < budget) begin
         step(1, 0, 0);
         n++;
      end
      if (ms != target) check("reach_phase", {5'd0, ms}, {5'd0, target});
   endtask

   initial begin
      model_reset();
      @(posedge clk);
      #1;
      check("reset_outputs", {phase, main_light, side_light, walk_light}, {3'd0, 2'd3, 2'd3, 1'b0});
      reset = 1'b1;

      repeat (22) step(1, 0, 0);

      step(1, 1, 0);
      run_until(SIDE_YEL, 20);
      run_until(MAIN_GREEN, 20);
      step(1, 0, 0);
      step(1, 1, 0);
      repeat (20) step(1, 0, 0);

      repeat (40) step(1, 1, 0);
      repeat (5) step(1, 0, 0);

      step(1, 1, 0);
      run_until(SIDE_GREEN, 20);
      step(1, 0, 1);
      repeat (20) step(1, 0, 0);
      check("walk_req_cleared", {7'd0, dut.walk_req}, {7'd0, wreq});

      repeat (10) step(1, 0, 0);
      step(1, 1, 1);
      repeat (20) step(1, 0, 0);

      repeat (300) step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                        $urandom_range(0, 15) == 0);
      repeat (12) step(1, 0, 0);

      step(1, 1, 0);
      run_until(SIDE_GREEN, 40);
      step(1, 0, 0);
      step(1, 0, 0);
      #2;
      reset = 1'b0;
      #1;
      check("async_reset", {phase, main_light, side_light, walk_light}, {3'd0, 2'd3, 2'd3, 1'b0});
      sb.delete();
      model_reset();
      #2;
      reset = 1'b1;
      repeat (10) step(1, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
